// File: rtl/scope_trigger_multi.sv
// Multi-channel logic-analyser trigger: per-channel level/edge hit detection,
// OR/AND combining, arm/holdoff/auto-rearm sequencing and a trigger counter.
module scope_trigger_multi #(
   parameter int NSIG     = 8,
   parameter int HOLDOFFW = 16,
   parameter int CNTW     = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NSIG-1:0]     sig,
   input  logic [3*NSIG-1:0]   conf,
   input  logic                combine,
   input  logic [HOLDOFFW-1:0] holdoff,
   input  logic                auto_rearm,
   input  logic                arm,
   input  logic                disarm,
   output logic [NSIG-1:0]     sigout,
   output logic                changed,
   output logic                triggered,
   output logic                armed,
   output logic [CNTW-1:0]     trig_count
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HOLDOFF} state_t;

   state_t              state_q, state_d;
   logic [HOLDOFFW-1:0] hcnt_q, hcnt_d;
   logic [NSIG-1:0]     sigout_q, sigout_d;
   logic                changed_q, changed_d;
   logic                triggered_q, triggered_d;
   logic                armed_q, armed_d;
   logic [CNTW-1:0]     trig_count_q, trig_count_d;

   logic [NSIG-1:0]     hit;
   logic [NSIG-1:0]     en;
   logic [1:0]          mode;
   logic                pol;
   logic                cond;

   // old value is the registered copy, new value is the live input
   always_comb begin
      hit  = '0;
      en   = '0;
      mode = '0;
      pol  = 1'b0;
      for (int i = 0; i < NSIG; i++) begin
         mode  = conf[3*i +: 2];
         pol   = conf[3*i+2];
         en[i] = (mode != 2'd0);
         case (mode)
            2'd1:    hit[i] = (sig[i] == pol);
            2'd2:    hit[i] = (sig[i] != sigout_q[i]) && (sig[i] == pol);
            2'd3:    hit[i] = (sig[i] != sigout_q[i]);
            default: hit[i] = 1'b0;
         endcase
      end
      if (combine) cond = (en != '0) && ((hit & en) == en);
      else         cond = ((hit & en) != '0);
   end

   always_comb begin
      state_d      = state_q;
      hcnt_d       = hcnt_q;
      trig_count_d = trig_count_q;
      triggered_d  = 1'b0;
      sigout_d     = sig;
      changed_d    = |(sig ^ sigout_q);
      if (disarm) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (arm) state_d = S_ARMED;
            S_ARMED: begin
               if (cond) begin
                  state_d      = S_HOLDOFF;
                  triggered_d  = 1'b1;
                  trig_count_d = trig_count_q + 1'b1;
                  hcnt_d       = holdoff;
               end
            end
            S_HOLDOFF: begin
               if (hcnt_q != '0) hcnt_d = hcnt_q - 1'b1;
               else              state_d = auto_rearm ? S_ARMED : S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
      armed_d = (state_d == S_ARMED);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         hcnt_q       <= '0;
         sigout_q     <= '0;
         changed_q    <= 1'b0;
         triggered_q  <= 1'b0;
         armed_q      <= 1'b0;
         trig_count_q <= '0;
      end else begin
         state_q      <= state_d;
         hcnt_q       <= hcnt_d;
         sigout_q     <= sigout_d;
         changed_q    <= changed_d;
         triggered_q  <= triggered_d;
         armed_q      <= armed_d;
         trig_count_q <= trig_count_d;
      end
   end

   assign sigout     = sigout_q;
   assign changed    = changed_q;
   assign triggered  = triggered_q;
   assign armed      = armed_q;
   assign trig_count = trig_count_q;

endmodule

// File: tb/tb_scope_trigger_multi.sv
// Bench for scope_trigger_multi: hand-written vector table, directed multi-cycle
// sequences and randomized stimulus checked against a behavioural model.
module tb_scope_trigger_multi;

   logic        clk;
   logic        rst_n;
   logic [7:0]  sig;
   logic [23:0] conf;
   logic        combine;
   logic [15:0] holdoff;
   logic        auto_rearm;
   logic        arm;
   logic        disarm;
   logic [7:0]  sigout;
   logic        changed;
   logic        triggered;
   logic        armed;
   logic [15:0] trig_count;

   int n_cmp = 0;
   int n_bad = 0;

   scope_trigger_multi dut (
      .clk(clk), .rst_n(rst_n), .sig(sig), .conf(conf), .combine(combine),
      .holdoff(holdoff), .auto_rearm(auto_rearm), .arm(arm), .disarm(disarm),
      .sigout(sigout), .changed(changed), .triggered(triggered), .armed(armed),
      .trig_count(trig_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   // m_phase: 0 idle, 1 waiting for a trigger, 2 holding off
   int          m_phase = 0;
   int          m_left  = 0;
   logic [7:0]  m_sigout = '0;
   logic        m_changed = 1'b0;
   logic        m_trig = 1'b0;
   logic [15:0] m_cnt = '0;

   function automatic bit model_cond();
      int n_en  = 0;
      int n_hit = 0;
      for (int i = 0; i < 8; i++) begin
         int md   = int'(conf[3*i +: 2]);
         bit p    = conf[3*i+2];
         bit nv   = sig[i];
         bit ov   = m_sigout[i];
         bit h    = 0;
         if (md != 0) begin
            n_en++;
            if (md == 1) h = (nv == p);
            if (md == 2) h = (nv != ov) && (nv == p);
            if (md == 3) h = (nv != ov);
            if (h) n_hit++;
         end
      end
      if (combine) return (n_en > 0) && (n_hit == n_en);
      return n_hit > 0;
   endfunction

   task automatic model_update();
      if (!rst_n) begin
         m_phase = 0; m_left = 0; m_sigout = '0; m_changed = 0; m_trig = 0; m_cnt = '0;
      end else begin
         bit c;
         c = model_cond();
         m_trig = 0;
         if (disarm) m_phase = 0;
         else if (m_phase == 0) begin
            if (arm) m_phase = 1;
         end else if (m_phase == 1) begin
            if (c) begin
               m_phase = 2; m_trig = 1; m_cnt = m_cnt + 16'd1; m_left = int'(holdoff);
            end
         end else begin
            if (m_left > 0) m_left--;
            else m_phase = auto_rearm ? 1 : 0;
         end
         m_changed = (sig != m_sigout);
         m_sigout  = sig;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock edge: advance the model, then compare every output against it
   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      check("sigout", 32'(sigout), 32'(m_sigout));
      check("changed", 32'(changed), 32'(m_changed));
      check("triggered", 32'(triggered), 32'(m_trig));
      check("armed", 32'(armed), 32'(m_phase == 1));
      check("trig_count", 32'(trig_count), 32'(m_cnt));
   endtask

   task automatic drive(input logic r, input logic [7:0] s, input logic [23:0] c, input logic cb,
                        input logic [15:0] h, input logic au, input logic a, input logic d);
      rst_n = r; sig = s; conf = c; combine = cb; holdoff = h; auto_rearm = au; arm = a; disarm = d;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst_n;
      logic [7:0]  sig;
      logic [23:0] conf;
      logic        comb;
      logic [15:0] hold;
      logic        au;
      logic        arm;
      logic        dis;
      logic [7:0]  e_sigout;
      logic        e_changed;
      logic        e_trig;
      logic        e_armed;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[20];

   int trig_seen;
   int last_idx;

   initial begin
      //           rst sig    conf      cb hold au arm dis | sigout chg trg arm cnt
      tbl[0]  = '{1'b0, 8'h00, 24'h000000, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[1]  = '{1'b1, 8'h01, 24'h000000, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 16'd0};
      tbl[2]  = '{1'b1, 8'h01, 24'h000000, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[3]  = '{1'b1, 8'h00, 24'h000006, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'd0};
      tbl[4]  = '{1'b1, 8'h01, 24'h000006, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 16'd1};
      tbl[5]  = '{1'b1, 8'h01, 24'h000006, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[6]  = '{1'b1, 8'h00, 24'h000006, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd1};
      tbl[7]  = '{1'b1, 8'h01, 24'h000002, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 16'd1};
      tbl[8]  = '{1'b1, 8'h00, 24'h000002, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'd2};
      tbl[9]  = '{1'b1, 8'h00, 24'h000002, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd2};
      tbl[10] = '{1'b1, 8'h00, 24'h000002, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd2};
      tbl[11] = '{1'b1, 8'h01, 24'h000002, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 16'd2};
      tbl[12] = '{1'b1, 8'h01, 24'h00002D, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 16'd2};
      tbl[13] = '{1'b1, 8'h03, 24'h00002D, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 16'd3};
      tbl[14] = '{1'b1, 8'h03, 24'h00002D, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 16'd3};
      tbl[15] = '{1'b1, 8'h01, 24'h00002D, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 16'd3};
      tbl[16] = '{1'b1, 8'h01, 24'h00002D, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 16'd4};
      tbl[17] = '{1'b1, 8'h00, 24'h000000, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd4};
      tbl[18] = '{1'b1, 8'h00, 24'h000000, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd4};
      tbl[19] = '{1'b1, 8'h00, 24'h000000, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd4};

      drive(1'b0, 8'h00, 24'h0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);

      // ---- table-driven vectors ----
      for (int v = 0; v < 20; v++) begin
         drive(tbl[v].rst_n, tbl[v].sig, tbl[v].conf, tbl[v].comb, tbl[v].hold,
               tbl[v].au, tbl[v].arm, tbl[v].dis);
         step();
         check($sformatf("tbl%0d_sigout", v), 32'(sigout), 32'(tbl[v].e_sigout));
         check($sformatf("tbl%0d_changed", v), 32'(changed), 32'(tbl[v].e_changed));
         check($sformatf("tbl%0d_trig", v), 32'(triggered), 32'(tbl[v].e_trig));
         check($sformatf("tbl%0d_armed", v), 32'(armed), 32'(tbl[v].e_armed));
         check($sformatf("tbl%0d_count", v), 32'(trig_count), 32'(tbl[v].e_cnt));
      end

      // ---- continuous level trigger, holdoff=3, auto-rearm: period 5 ----
      drive(1'b1, 8'h01, 24'h000005, 1'b0, 16'd3, 1'b1, 1'b1, 1'b0);
      step();
      arm = 1'b0;
      trig_seen = 0;
      last_idx  = -1;
      for (int k = 0; k < 22; k++) begin
         step();
         if (triggered) begin
            if (last_idx >= 0) check("pulse_period", 32'(k - last_idx), 32'd5);
            check("pulse_count", 32'(trig_count), 32'(4 + trig_seen + 1));
            trig_seen++;
            last_idx = k;
         end
      end
      check("pulses_seen", 32'(trig_seen), 32'd5);

      // ---- disarm during holdoff: no more triggers ----
      while (!triggered && trig_seen < 100) begin
         step();
         trig_seen++;
      end
      disarm = 1'b1;
      step();
      disarm = 1'b0;
      trig_seen = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (triggered) trig_seen++;
      end
      check("after_disarm_trigs", 32'(trig_seen), 32'd0);
      check("after_disarm_armed", 32'(armed), 32'd0);

      // ---- reset mid-holdoff ----
      arm = 1'b1;
      step();
      arm = 1'b0;
      step();
      check("pre_reset_trig", 32'(triggered), 32'd1);
      rst_n = 1'b0;
      step();
      check("rst_outputs", {8'(sigout), 1'(changed), 1'(triggered), 1'(armed), 16'(trig_count)}, 32'd0);
      rst_n = 1'b1;

      // ---- randomized stimulus against the model ----
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 1) == 0) sig = 8'($urandom);
         if ($urandom_range(0, 7) == 0) conf = 24'($urandom);
         combine    = 1'($urandom_range(0, 1));
         holdoff    = 16'($urandom_range(0, 4));
         auto_rearm = 1'($urandom_range(0, 1));
         arm        = ($urandom_range(0, 3) == 0);
         disarm     = ($urandom_range(0, 15) == 0);
         rst_n      = ($urandom_range(0, 63) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
